// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU front-end sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        LATCH = 2'd2
    } seq_state_e;

    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_OP   = 2;
    localparam int BTN_EXEC = 3;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_AND = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4;
    localparam logic [5:0] OP_NOR = 6'd5;
    localparam logic [5:0] OP_SRL = 6'd6;
    localparam logic [5:0] OP_SRA = 6'd7;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; results truncated to NB_DATA, no carry-out
module ALU
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    logic [5:0] op6;

    always_comb begin
        op6 = 6'(i_op);
        case (op6)
            OP_ADD:  o_result = i_data_a + i_data_b;
            OP_SUB:  o_result = i_data_a - i_data_b;
            OP_AND:  o_result = i_data_a & i_data_b;
            OP_OR:   o_result = i_data_a | i_data_b;
            OP_XOR:  o_result = i_data_a ^ i_data_b;
            OP_NOR:  o_result = ~(i_data_a | i_data_b);
            OP_SRL:  o_result = i_data_a >> i_data_b;
            OP_SRA:  o_result = $unsigned($signed(i_data_a) >>> i_data_b);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - 2-FF synchroniser, debouncer and rising-edge pulse for one button
module btn_conditioner #(
    parameter int DBNC_CYCLES = 100000,
    parameter int NB_DBNC     = 17
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0]         sync_q;
    logic [NB_DBNC-1:0] cnt_q, cnt_d;
    logic               stable_q, stable_d;
    logic               edge_q;

    // The stable level flips on the DBNC_CYCLES-th consecutive mismatching cycle.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == NB_DBNC'(DBNC_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_btn};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            edge_q   <= stable_q;
        end
    end

    assign o_pulse = stable_q & ~edge_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - button-driven operand loading and execute sequencer around the ALU
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NB_BTN      = 4,
    parameter int NB_OP       = 6,
    parameter int NB_AB       = 8,
    parameter int DBNC_CYCLES = 100000,
    parameter int NB_DBNC     = 17
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_AB-1:0]  i_sw,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic              i_acc,
    output logic [NB_AB-1:0]  o_led,
    output logic              o_zero,
    output logic              o_valid,
    output logic              o_busy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_EXEC  = EXEC;
    localparam logic [1:0] ST_LATCH = LATCH;

    logic [NB_BTN-1:0] btn_pulse;
    logic [NB_AB-1:0]  alu_result;

    logic [1:0]       state_q, state_d;
    logic [NB_AB-1:0] a_q, a_d;
    logic [NB_AB-1:0] b_q, b_d;
    logic [NB_OP-1:0] op_q, op_d;
    logic [NB_AB-1:0] res_q, res_d;
    logic [NB_AB-1:0] led_q, led_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
        btn_conditioner #(
            .DBNC_CYCLES(DBNC_CYCLES),
            .NB_DBNC    (NB_DBNC)
        ) u_btn (
            .clock  (clock),
            .i_reset(i_reset),
            .i_btn  (i_btn[g]),
            .o_pulse(btn_pulse[g])
        );
    end

    ALU #(
        .NB_DATA(NB_AB),
        .NB_OP  (NB_OP)
    ) u_alu (
        .i_data_a(a_q),
        .i_data_b(b_q),
        .i_op    (op_q),
        .o_result(alu_result)
    );

    // Same-cycle pulses resolve by priority; losers are dropped, not queued.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        led_d   = led_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_pulse[BTN_A]) begin
                    a_d     = i_sw;
                    valid_d = 1'b0;
                end else if (btn_pulse[BTN_B]) begin
                    b_d     = i_sw;
                    valid_d = 1'b0;
                end else if (btn_pulse[BTN_OP]) begin
                    op_d    = i_sw[NB_OP-1:0];
                    valid_d = 1'b0;
                end else if (btn_pulse[BTN_EXEC]) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                led_d   = res_q;
                zero_d  = (res_q == '0);
                valid_d = 1'b1;
                if (i_acc) begin
                    a_d = res_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            led_q   <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            led_q   <= led_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign o_led   = led_q;
    assign o_zero  = zero_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised successor to the switch/button ALU front end. It conditions each push-button through a synchroniser, a debouncer and a rising-edge detector, then loads the operand A, operand B and opcode registers from the switches. An explicit execute button runs a small sequencer that registers the ALU result, a zero flag and a valid flag onto the LEDs. An optional accumulate mode writes each result back into operand A. It sits between the board I/O and the existing `ALU` instance at the top of the FPGA design.

## Interface
- `NB_BTN`, 4, number of buttons: 0=load A, 1=load B, 2=load op, 3=execute; fixed at 4.
- `NB_OP`, 6, opcode width.
- `NB_AB`, 8, operand/result width; must be ≥ `NB_OP`.
- `DBNC_CYCLES`, 100000, consecutive stable cycles required to accept a button level change; must be ≥ 1.
- `NB_DBNC`, 17, debounce counter width; must satisfy 2^`NB_DBNC` > `DBNC_CYCLES`.

Ports:
- `clock` in 1: single system clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_sw` in `NB_AB`: operand/opcode switches; the opcode uses `i_sw[NB_OP-1:0]`.
- `i_btn` in `NB_BTN`: raw asynchronous buttons, active-high.
- `i_acc` in 1: accumulate mode, sampled in LATCH.
- `o_led` out `NB_AB`: registered result.
- `o_zero` out 1: registered result == 0.
- `o_valid` out 1: `o_led` reflects the current operands.
- `o_busy` out 1: sequencer not in IDLE.

## Operation
- Button path, per button:
  - 2-FF synchroniser.
  - Debouncer: the counter increments while the synced level ≠ the stable level. It clears when they are equal. When the count reaches `DBNC_CYCLES`, the stable level flips and the counter clears.
  - Rising edge of the stable level produces a 1-cycle pulse.
- Load pulses are accepted only in IDLE:
  - btn0: `a_q <= i_sw`.
  - btn1: `b_q <= i_sw`.
  - btn2: `op_q <= i_sw[NB_OP-1:0]`.
  - Any accepted load clears `o_valid` on the same edge.
- Pulses arriving in the same cycle: priority btn0 > btn1 > btn2 > btn3. Lower-priority pulses in that cycle are discarded, not queued.
- FSM states:
  - IDLE: btn3 pulse (and no higher-priority pulse) → EXEC.
  - EXEC: `res_q <= alu_result` → LATCH. All pulses are ignored.
  - LATCH: `o_led <= res_q`, `o_zero <= (res_q == 0)`, `o_valid <= 1`. If `i_acc`, then `a_q <= res_q`. Next state IDLE. All pulses are ignored.
  - Illegal state encoding → IDLE.
- `o_busy` = (state ≠ IDLE), combinational from the state register.
- Arithmetic and width rules belong to `ALU`: results are truncated to `NB_AB`, with no carry-out.

## Timing
- Reset values: `o_led`=0, `o_zero`=0, `o_valid`=0, `o_busy`=0. `a_q`, `b_q`, `op_q`, `res_q`, synchroniser flops, debounce counters, stable levels and edge flops all reset to 0. State resets to IDLE.
- Button press to pulse: 2 (sync) + `DBNC_CYCLES` + 1 (edge) cycles.
- Execute pulse sampled at edge t:
  - State = EXEC after t.
  - `res_q` valid after t+1.
  - `o_led`/`o_valid` updated after t+2.
  - `o_busy` is high during t+1..t+2.
- Back-to-back execute is allowed: an execute pulse in the first IDLE cycle after LATCH is accepted.
- Reset asserted mid-EXEC or mid-LATCH: all state and outputs return to reset values immediately. A pending result is lost.
- Reset deassertion must be synchronised externally to `clock`. The block performs no internal reset synchronisation.

## Structure
- Package `alu_seq_pkg`:
  - State enum: IDLE, EXEC, LATCH (2-bit).
  - Button index constants: `BTN_A`, `BTN_B`, `BTN_OP`, `BTN_EXEC`.
- Sub-module `btn_conditioner` (sync + debounce + edge; parameters `DBNC_CYCLES`, `NB_DBNC`), instantiated `NB_BTN` times in a generate loop.
- The existing `ALU` is instantiated unchanged, fed from `a_q`, `b_q`, `op_q`.

## Test plan
All scenarios use `DBNC_CYCLES`=4, `NB_AB`=4, `NB_OP`=4.
- Basic add: load A=3, B=5, op=ADD, press execute → `o_led`=8, `o_zero`=0. `o_valid` rises exactly 2 cycles after the execute pulse; `o_busy` is high for exactly those 2 cycles.
- Bounce rejection: toggle btn0 high for 3 cycles, low, high for 3 cycles with `i_sw`=7 → `a_q` unchanged (0). Then hold btn0 high for 10 cycles → `a_q`=7, with exactly one pulse.
- Wrap and zero: A=15, B=1, ADD, execute → `o_led`=0, `o_zero`=1, `o_valid`=1. Then load B=2 → `o_valid`=0 while `o_led` stays 0.
- Accumulate: A=1, B=1, ADD, `i_acc`=1, execute three times → `o_led` sequence 2, 3, 4; `a_q` ends at 4.
- Simultaneous load: btn0 and btn1 pulses in the same cycle with `i_sw`=9 → `a_q`=9, `b_q` unchanged. Any btn pulse during EXEC/LATCH leaves the operands unchanged.
- Reset mid-operation: assert `i_reset` low while in EXEC → all outputs 0 and state IDLE without waiting for a clock edge. After release, an execute with A=B=0 and ADD → `o_led`=0, `o_zero`=1.
